// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle between execute stage and muldiv_unit
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one result bit per cycle
// Signed operations run on magnitudes; the sign is re-applied on the way into DONE.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic            neg;
  logic [XLEN-1:0] opnd;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] result_q;

  logic            accept;
  logic            sgn_a, sgn_b, a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            fast;
  logic [XLEN-1:0] fast_val;

  always_comb begin
    sgn_a    = bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    sgn_b    = bus.funct3 inside {3'b001, 3'b100, 3'b110};
    a_neg    = sgn_a & bus.op_a[XLEN-1];
    b_neg    = sgn_b & bus.op_b[XLEN-1];
    a_mag    = a_neg ? -bus.op_a : bus.op_a;
    b_mag    = b_neg ? -bus.op_b : bus.op_b;
    // remainder sign follows the dividend; everything else is the product of signs
    neg_in   = (bus.funct3[2] & bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
    fast     = 1'b0;
    fast_val = '0;
    if (bus.funct3[2]) begin
      if (bus.op_b == '0) begin
        fast     = 1'b1;
        fast_val = bus.funct3[1] ? bus.op_a : '1;
      end else if (!bus.funct3[0] && bus.op_a == MIN_NEG && bus.op_b == '1) begin
        fast     = 1'b1;
        fast_val = bus.funct3[1] ? '0 : bus.op_a;
      end
    end
  end

  // acc/lo double as {product_hi, product_lo} for multiply and {remainder, quotient} for divide
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   acc_nxt, lo_nxt;
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   rem_fin, quo_fin, calc_res;

  always_comb begin
    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    shifted = {acc, lo[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    if (op[2]) begin
      acc_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_nxt  = {lo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      acc_nxt = mul_sum[XLEN:1];
      lo_nxt  = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod_fin = neg ? -{acc_nxt, lo_nxt} : {acc_nxt, lo_nxt};
    rem_fin  = neg ? -acc_nxt : acc_nxt;
    quo_fin  = neg ? -lo_nxt : lo_nxt;
    if (op[2])
      calc_res = op[1] ? rem_fin : quo_fin;
    else
      calc_res = (op[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
  end

  always_comb begin
    accept    = bus.start & ~bus.flush & (state != CALC);
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = accept ? (fast ? DONE : CALC) : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      op       <= '0;
      neg      <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      lo       <= '0;
      result_q <= '0;
    end else if (accept) begin
      op   <= bus.funct3;
      neg  <= neg_in;
      cnt  <= CW'(XLEN-1);
      acc  <= '0;
      opnd <= bus.funct3[2] ? b_mag : a_mag;
      lo   <= bus.funct3[2] ? a_mag : b_mag;
      if (fast) result_q <= fast_val;
    end else if (state == CALC && !bus.flush) begin
      acc <= acc_nxt;
      lo  <= lo_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == '0) result_q <= calc_res;
    end
  end

  assign bus.busy   = (state == CALC);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(XLEN)) bus();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_res = '0;

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0]     p;
    case (f3)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
    return XLEN + 1;
  endfunction

  // called at a negedge; returns at the negedge of the cycle where done is seen (or the bound expires)
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int bcnt);
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op_a   = $urandom;
    bus.op_b   = $urandom;
    bus.funct3 = 3'($urandom);
    lat  = 1;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    res = bus.result;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++;
    if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
  endtask

  task automatic test_directed();
    logic [2:0]  f3s  [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] as   [4] = '{32'd7, MINV, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs   [4] = '{32'hFFFF_FFFD, MINV, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] exps [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] res;
    int lat, bcnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      do_op(f3s[i], as[i], bs[i], res, lat, bcnt);
      n_checks++;
      if (res !== exps[i]) begin n_fail++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, exps[i]); end
      n_checks++;
      if (lat != 33) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want 33", i, lat); end
      n_checks++;
      if (bcnt != 32) begin n_fail++; $display("FAIL directed_busy_cycles[%0d]: got %0d want 32", i, bcnt); end
      last_res = exps[i];
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3s  [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] as   [4] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] bs   [4] = '{32'd7, 32'd7, 32'd2, 32'd2};
    logic [31:0] exps [4] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [31:0] res;
    int lat, bcnt;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      do_op(f3s[i], as[i], bs[i], res, lat, bcnt);
      n_checks++;
      if (res !== exps[i] || lat != 33) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %h lat %0d want %h lat 33", i, res, lat, exps[i]);
      end
      last_res = exps[i];
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  f3s  [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] as   [4] = '{32'h1234_5678, 32'd5, MINV, MINV};
    logic [31:0] bs   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps [4] = '{32'hFFFF_FFFF, 32'd5, MINV, 32'h0};
    logic [31:0] res;
    int lat, bcnt;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      do_op(f3s[i], as[i], bs[i], res, lat, bcnt);
      n_checks++;
      if (res !== exps[i]) begin n_fail++; $display("FAIL fast_result[%0d]: got %h want %h", i, res, exps[i]); end
      n_checks++;
      if (lat != 1 || bcnt != 0) begin
        n_fail++;
        $display("FAIL fast_timing[%0d]: got lat %0d busy %0d want lat 1 busy 0", i, lat, bcnt);
      end
      last_res = exps[i];
    end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    @(negedge clk);
    bus.funct3 = 3'b000; bus.op_a = 32'd5; bus.op_b = 32'd6; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n < 10; n++) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL flush_stop: got busy %b done %b want 0 0", bus.busy, bus.done);
    end
    seen = 0;
    // start and flush together: the request must be dropped
    bus.funct3 = 3'b101; bus.op_a = 32'd9; bus.op_b = 32'd0; bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d active cycles want 0", seen); end
    n_checks++;
    if (bus.result !== last_res) begin n_fail++; $display("FAIL flush_result_hold: got %h want %h", bus.result, last_res); end
  endtask

  task automatic test_start_in_calc();
    logic [31:0] exp_res;
    int dones, first;
    exp_res = ref_model(3'b011, 32'hDEAD_BEEF, 32'h1357_9BDF);
    bus.funct3 = 3'b011; bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'h1357_9BDF; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    first = 0;
    for (int n = 1; n < 70; n++) begin
      if (n == 5) begin
        bus.funct3 = 3'b101; bus.op_a = 32'd1; bus.op_b = 32'd0; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        dones++;
        if (first == 0) first = n;
        n_checks++;
        if (bus.result !== exp_res) begin n_fail++; $display("FAIL calc_start_result: got %h want %h", bus.result, exp_res); end
      end
      @(negedge clk);
    end
    n_checks++;
    if (dones != 1 || first != 33) begin
      n_fail++; $display("FAIL calc_start_ignored: got %0d dones first at %0d want 1 at 33", dones, first);
    end
    last_res = exp_res;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat, bcnt;
    bus.funct3 = 3'b100; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n < 8; n++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid: got busy %b done %b result %h want 0 0 0", bus.busy, bus.done, bus.result);
    end
    reset = 1'b0;
    @(negedge clk);
    do_op(3'b000, 32'd3, 32'd4, res, lat, bcnt);
    n_checks++;
    if (res !== 32'd12 || lat != 33) begin
      n_fail++; $display("FAIL reset_then_mul: got %h lat %0d want 0000000c lat 33", res, lat);
    end
    last_res = 32'd12;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return MINV;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b, res, exp_res;
    int lat, bcnt, exp_lat;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      exp_res = ref_model(f3, a, b);
      exp_lat = ref_latency(f3, a, b);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      do_op(f3, a, b, res, lat, bcnt);
      n_checks++;
      if (res !== exp_res || lat != exp_lat || bcnt != exp_lat - 1) begin
        n_fail++;
        $display("FAIL random[%0d] f3=%0d a=%h b=%h: got %h lat %0d busy %0d want %h lat %0d busy %0d",
                 i, f3, a, b, res, lat, bcnt, exp_res, exp_lat, exp_lat - 1);
      end
      last_res = exp_res;
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_directed();
    test_back_to_back();
    test_fast_path();
    test_flush();
    test_start_in_calc();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit, parametrised in operand width, executing the eight M-extension operations selected by funct3. It sits beside the single-cycle ALU in the execute stage and is entered when the decoder flags an M-extension instruction (aluCtrlOp = 2'b11, funct7 = 7'b0000001). It computes one bit per cycle and stalls the pipeline through `busy`. Division by zero and signed overflow are resolved on a one-cycle fast path.

## Interface
- `XLEN`, default 32: operand and result width; must be ≥ 4 and even.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted when `busy` = 0.
- `funct3`  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  XLEN  rs1 operand (multiplicand / dividend).
- `op_b`  in  XLEN  rs2 operand (multiplier / divisor).
- `flush`  in  1  synchronous abort of the in-flight operation.
- `busy`  out  1  high while in CALC; the pipeline stalls on it.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  XLEN  registered result, held until the next accepted completion.

## Operation
- FSM states: IDLE, CALC, DONE.
- `start` is accepted in IDLE or DONE; back-to-back issue is allowed. In CALC, `start` is ignored.
- On accept, the unit latches funct3 and the operands, converts signed operands to magnitudes, and records the result sign.
  - Signed: op_a and op_b for MULH/DIV/REM; op_a only for MULHSU.
  - MUL is computed with unsigned magnitudes; the low XLEN bits are identical.
- IDLE → CALC on accept; the CALC counter loads XLEN-1.
- CALC, multiply: shift-add of the 2·XLEN partial product, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC → DONE when the counter reaches 0, after XLEN CALC cycles. On entry to DONE:
  - Apply sign correction (two's-complement negate when the sign flag is set).
  - MUL takes product[XLEN-1:0]; MULH/MULHSU/MULHU take product[2·XLEN-1:XLEN].
  - DIV/DIVU take the quotient; REM/REMU take the remainder. The remainder sign follows the dividend.
- Fast path, decided at accept (IDLE/DONE → DONE directly):
  - op_b = 0 with DIV/DIVU: result = all ones.
  - op_b = 0 with REM/REMU: result = op_a.
  - DIV with op_a = 1<<(XLEN-1) and op_b = all ones: result = op_a.
  - REM with the same operands: result = 0.
- DONE → IDLE when no `start`; DONE → CALC (or DONE via the fast path) on `start`.
- `flush`: any state → IDLE next edge. No `done`; `result` unchanged. If `start` and `flush` arrive together, `flush` wins and the request is dropped.
- `reset` dominates `flush` and `start`.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, counter 0, internal registers 0.
- Accept at edge E0.
  - Normal op: `busy` = 1 for cycles E0+1 … E0+XLEN; `done` = 1 for the cycle after edge E0+XLEN+1. Latency is XLEN+1 cycles (33 at XLEN = 32).
  - Fast path: `done` = 1 for the cycle after edge E0+1; `busy` stays 0.
- `done` is never high two consecutive cycles for the same operation. A back-to-back fast-path accept in DONE produces a fresh `done` the next cycle.
- Operands may change after the accept edge; the unit uses only the latched copies.
- Reset asserted mid-CALC: all outputs return to their reset values at the next edge. No `done` is issued.

## Test plan
- MUL, op_a = 7, op_b = 0xFFFFFFFD (−3) → `result` = 0xFFFFFFEB; `done` pulses 33 cycles after accept; `busy` is high for exactly 32 cycles.
- MULH, 0x80000000 × 0x80000000 → 0x40000000. MULHU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU, 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF. Issue each with `start` in the DONE cycle of the previous op (back-to-back).
- Fast paths:
  - DIVU x/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
  - Each gives `done` one cycle after accept with `busy` = 0.
- `flush` at CALC cycle 10 → `busy` low next cycle, no `done`, `result` holds its previous value. `start` pulsed during CALC → ignored, and only one `done` occurs.
- `reset` mid-CALC → `busy`/`done`/`result` = 0 next cycle. A new MUL 3×4 issued afterwards → 12.
